ccc_cfg_sequencer: RTL and testbench

Bring-up and reconfiguration sequencer for the fabric clock conditioning circuit (FCCC/CCC). It holds the PLL in reset, writes a parameterised list of configuration bytes over the CCC's APB configuration port, releases the PLL, and qualifies LOCK. It then drives a lock-qualified reset to downstream fabric logic and watches for loss of lock. It sits between the CCC instance and the system reset tree, clocked from the always-available APB clock.

---
 rtl/ccc_cfg_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_ccc_cfg_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccc_cfg_sequencer.sv
// Purpose: CCC bring-up sequencer - PLL reset, APB config writes, LOCK qualification, fabric reset release.
// Latency: all outputs registered; CCC_LOCK reaches the FSM through a 2-flop synchronizer.
// Backpressure: stalls in WR_WAIT while CCC_BUSY=1; APB access is fixed at one cycle (no PREADY).
//
// Ports:
//   PCLK, PRESET_N          : clock, async active-low reset
//   START                   : single-cycle (re)run request (IDLE/RUN/ERROR only)
//   CFG_ADDR / CFG_DATA     : NUM_BYTES packed 6-bit addresses / 8-bit data, held stable by the user
//   CCC_BUSY, CCC_LOCK      : CCC config-port busy, asynchronous PLL lock
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB write master
//   PLL_ARST_N, SYS_RESET_N, DONE, ERR, LOCK_LOST, STATE : PLL reset, fabric reset, status, debug state
module ccc_cfg_sequencer #(
  parameter int NUM_BYTES    = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic                   PCLK,
  input  logic                   PRESET_N,
  input  logic                   START,
  input  logic [6*NUM_BYTES-1:0] CFG_ADDR,
  input  logic [8*NUM_BYTES-1:0] CFG_DATA,
  input  logic                   CCC_BUSY,
  input  logic                   CCC_LOCK,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [5:0]             PADDR,
  output logic [7:0]             PWDATA,
  output logic                   PLL_ARST_N,
  output logic                   SYS_RESET_N,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   LOCK_LOST,
  output logic [2:0]             STATE
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WR_WAIT   = 3'd2,
    S_WR_SETUP  = 3'd3,
    S_WR_ACCESS = 3'd4,
    S_WAIT_LOCK = 3'd5,
    S_RUN       = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             auto_q, auto_d;
  logic             err_q, err_d;
  logic             lost_q, lost_d;
  logic [5:0]       paddr_q, paddr_d;
  logic [7:0]       pwdata_q, pwdata_d;
  logic             psel_q, penable_q, pwrite_q, pll_q, run_q;
  logic             psel_d, penable_d, pll_d, run_d;
  logic             sync1_q, lock_s_q;
  logic             start_ok;

  // Two-flop synchronizer: lock_s_q is the only form of CCC_LOCK the FSM sees.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= CCC_LOCK;
      lock_s_q <= sync1_q;
    end
  end

  assign start_ok = START && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERROR);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_cnt_d = '0;
    stable_d  = '0;
    tmo_d     = '0;
    auto_d    = auto_q;
    err_d     = err_q;
    lost_d    = lost_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      S_IDLE: begin
        if (auto_q) begin
          state_d = S_PLL_RST;
          auto_d  = 1'b0;
        end
      end
      S_PLL_RST: begin
        idx_d = '0;
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = S_WR_WAIT;
        else                                     rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_WR_WAIT: begin
        if (!CCC_BUSY) begin
          state_d  = S_WR_SETUP;
          // Address/data are loaded here so they are valid for the whole SETUP+ACCESS pair.
          paddr_d  = CFG_ADDR[6*int'(idx_q) +: 6];
          pwdata_d = CFG_DATA[8*int'(idx_q) +: 8];
        end
      end
      S_WR_SETUP: state_d = S_WR_ACCESS;
      S_WR_ACCESS: begin
        if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
          state_d = S_WAIT_LOCK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WR_WAIT;
        end
      end
      S_WAIT_LOCK: begin
        // Stable is checked first so a simultaneous timeout loses to lock.
        if (stable_q == STB_W'(LOCK_STABLE)) begin
          state_d = S_RUN;
        end else if (tmo_q == TMO_W'(LOCK_TIMEOUT)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d    = tmo_q + 1'b1;
          stable_d = lock_s_q ? stable_q + 1'b1 : '0;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          lost_d  = 1'b1;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // A restart overrides everything above, including a lock loss in the same cycle.
    if (start_ok) begin
      state_d = S_PLL_RST;
      auto_d  = 1'b0;
      err_d   = 1'b0;
      lost_d  = 1'b0;
    end
    if (state_d == S_ERROR) err_d = 1'b1;

    psel_d    = (state_d == S_WR_SETUP) || (state_d == S_WR_ACCESS);
    penable_d = (state_d == S_WR_ACCESS);
    pll_d     = (state_d == S_WAIT_LOCK) || (state_d == S_RUN);
    run_d     = (state_d == S_RUN);
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rst_cnt_q <= '0;
      stable_q  <= '0;
      tmo_q     <= '0;
      auto_q    <= AUTO_START;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pll_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_cnt_q <= rst_cnt_d;
      stable_q  <= stable_d;
      tmo_q     <= tmo_d;
      auto_q    <= auto_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= psel_d;
      pll_q     <= pll_d;
      run_q     <= run_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PLL_ARST_N  = pll_q;
  assign SYS_RESET_N = run_q;
  assign DONE        = run_q;
  assign ERR         = err_q;
  assign LOCK_LOST   = lost_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_ccc_cfg_sequencer.sv
// Purpose: directed + randomized-config bench for ccc_cfg_sequencer.
// Latency: expected edges come from closed-form timing of the sequence phases.
// Backpressure: CCC_BUSY stall injected before byte 2; expected delay is the stall length.
module tb_ccc_cfg_sequencer;

  localparam int NB  = 4;
  localparam int RST = 4;
  localparam int LS  = 8;
  localparam int LT  = 100;
  // Edges from launch edge (inclusive) to WAIT_LOCK entry and to DONE.
  localparam int T_WL   = 1 + RST + 3 * NB;
  localparam int T_DONE = T_WL + LS + 1;

  logic            PCLK = 1'b0;
  logic            PRESET_N = 1'b0;
  logic            START = 1'b0;
  logic [6*NB-1:0] CFG_ADDR = '0;
  logic [8*NB-1:0] CFG_DATA = '0;
  logic            CCC_BUSY = 1'b0;
  logic            CCC_LOCK = 1'b0;
  logic            PSEL, PENABLE, PWRITE;
  logic [5:0]      PADDR;
  logic [7:0]      PWDATA;
  logic            PLL_ARST_N, SYS_RESET_N, DONE, ERR, LOCK_LOST;
  logic [2:0]      STATE;

  ccc_cfg_sequencer #(
    .NUM_BYTES(NB), .RST_CYCLES(RST), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .AUTO_START(1'b1)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .START(START),
    .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .CCC_BUSY(CCC_BUSY), .CCC_LOCK(CCC_LOCK),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PLL_ARST_N(PLL_ARST_N), .SYS_RESET_N(SYS_RESET_N), .DONE(DONE),
    .ERR(ERR), .LOCK_LOST(LOCK_LOST), .STATE(STATE)
  );

  always #5 PCLK = ~PCLK;

  int edge_n = 0;
  always @(posedge PCLK) edge_n <= edge_n + 1;

  // APB monitor: log each completed write and count PSEL-high cycles.
  logic [13:0] wr_log[$];
  int          psel_cyc = 0;
  always @(negedge PCLK) begin
    if (PRESET_N && PSEL && PENABLE) wr_log.push_back({PADDR, PWDATA});
    if (PRESET_N && PSEL) psel_cyc <= psel_cyc + 1;
  end

  int          errors = 0;
  int          checks = 0;
  logic [5:0]  exp_a[NB];
  logic [7:0]  exp_d[NB];

  task automatic step();
    @(negedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_cfg();
    for (int i = 0; i < NB; i++) begin
      exp_a[i] = 6'($urandom);
      exp_d[i] = 8'($urandom);
      CFG_ADDR[6*i +: 6] = exp_a[i];
      CFG_DATA[8*i +: 8] = exp_d[i];
    end
  endtask

  task automatic chk_writes(input string tag, input int base);
    chk({tag, "_count"}, 32'(wr_log.size() - base), 32'(NB));
    for (int i = 0; i < NB; i++)
      if (base + i < wr_log.size())
        chk({tag, "_wr"}, 32'(wr_log[base + i]), 32'({exp_a[i], exp_d[i]}));
  endtask

  task automatic pulse_start(output int s_edge);
    START = 1'b1;
    step();
    s_edge = edge_n;
    START = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && DONE !== 1'b1; i++) step();
  endtask

  initial begin
    int base, s_edge, e_edge, k, r, lbase, pbase, rst_cyc, pll_rel;

    // ---- reset values ----
    new_cfg();
    CCC_LOCK = 1'b1;
    repeat (3) step();
    chk("rst_apb", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
    chk("rst_pll", 32'(PLL_ARST_N), 32'd0);
    chk("rst_sys_done", 32'({SYS_RESET_N, DONE}), 32'd0);
    chk("rst_flags", 32'({ERR, LOCK_LOST}), 32'd0);
    chk("rst_state", 32'(STATE), 32'd0);

    // ---- auto bring-up ----
    lbase = wr_log.size();
    pbase = psel_cyc;
    PRESET_N = 1'b1;
    base = edge_n;
    rst_cyc = 0;
    pll_rel = -1;
    for (int i = 0; i < 200 && DONE !== 1'b1; i++) begin
      step();
      if (STATE == 3'd1) rst_cyc++;
      if (PLL_ARST_N === 1'b1 && pll_rel < 0) pll_rel = edge_n - base;
    end
    chk("boot_done", 32'(DONE), 32'd1);
    chk("boot_done_edge", 32'(edge_n - base), 32'(T_DONE));
    chk("boot_pll_rst_cycles", 32'(rst_cyc), 32'(RST));
    chk("boot_pll_release_edge", 32'(pll_rel), 32'(T_WL));
    chk("boot_sys_reset", 32'(SYS_RESET_N), 32'd1);
    chk("boot_psel_cycles", 32'(psel_cyc - pbase), 32'(2 * NB));
    chk_writes("boot", lbase);

    // ---- BUSY stall before byte 2 ----
    new_cfg();
    lbase = wr_log.size();
    pbase = psel_cyc;
    pulse_start(s_edge);
    for (int i = 0; i < 100 && wr_log.size() - lbase < 2; i++) step();
    chk("busy_two_bytes", 32'(wr_log.size() - lbase), 32'd2);
    CCC_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_psel_low", 32'(PSEL), 32'd0);
    end
    step();
    CCC_BUSY = 1'b0;
    wait_done(200);
    chk("busy_done_edge", 32'(edge_n - s_edge + 1), 32'(T_DONE + 5));
    chk("busy_psel_cycles", 32'(psel_cyc - pbase), 32'(2 * NB));
    chk_writes("busy", lbase);

    // ---- one-cycle lock glitch in WAIT_LOCK ----
    new_cfg();
    pulse_start(s_edge);
    for (int i = 0; i < 100 && STATE !== 3'd5; i++) step();
    e_edge = edge_n;
    chk("glitch_wl_entry", 32'(e_edge - s_edge + 1), 32'(T_WL));
    repeat (4) step();
    CCC_LOCK = 1'b0;           // sampled by the synchronizer at edge e_edge+5 only
    step();
    CCC_LOCK = 1'b1;
    wait_done(100);
    chk("glitch_done_edge", 32'(edge_n - e_edge), 32'(5 + 3 + LS));

    // ---- loss of lock in RUN ----
    lbase = wr_log.size();
    pbase = psel_cyc;
    CCC_LOCK = 1'b0;
    k = edge_n;
    for (int i = 0; i < 10 && SYS_RESET_N !== 1'b0; i++) step();
    chk("loss_sysrst_edge", 32'(edge_n - k), 32'd3);
    chk("loss_flags", 32'({LOCK_LOST, DONE, STATE}), 32'({1'b1, 1'b0, 3'd5}));
    repeat (20) step();
    chk("loss_pll_held", 32'(PLL_ARST_N), 32'd1);
    CCC_LOCK = 1'b1;
    r = edge_n;
    wait_done(100);
    chk("relock_done_edge", 32'(edge_n - r), 32'(LS + 3));
    chk("relock_lost_sticky", 32'(LOCK_LOST), 32'd1);
    chk("loss_no_apb", 32'(psel_cyc - pbase), 32'd0);

    // ---- START beats simultaneous lock loss, then timeout ----
    CCC_LOCK = 1'b0;
    step();
    step();
    pulse_start(s_edge);
    chk("start_prio", 32'({LOCK_LOST, STATE}), 32'({1'b0, 3'd1}));
    for (int i = 0; i < 100 && STATE !== 3'd5; i++) step();
    e_edge = edge_n;
    for (int i = 0; i < 300 && ERR !== 1'b1; i++) step();
    chk("tmo_err_edge", 32'(edge_n - e_edge), 32'(LT + 1));
    chk("tmo_outputs", 32'({ERR, PLL_ARST_N, SYS_RESET_N, DONE, STATE}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd7}));
    repeat (5) step();
    chk("tmo_err_sticky", 32'(ERR), 32'd1);
    CCC_LOCK = 1'b1;
    new_cfg();
    lbase = wr_log.size();
    pulse_start(s_edge);
    chk("tmo_restart", 32'({ERR, STATE}), 32'({1'b0, 3'd1}));
    wait_done(200);
    chk("tmo_rerun_done_edge", 32'(edge_n - s_edge + 1), 32'(T_DONE));
    chk_writes("tmo_rerun", lbase);

    // ---- async reset during WR_ACCESS of byte 1 ----
    new_cfg();
    lbase = wr_log.size();
    pulse_start(s_edge);
    for (int i = 0; i < 100 && wr_log.size() - lbase < 2; i++) step();
    chk("arst_in_access", 32'({PSEL, PENABLE}), 32'b11);
    PRESET_N = 1'b0;
    #1;
    chk("arst_apb", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
    chk("arst_status", 32'({PLL_ARST_N, SYS_RESET_N, DONE, ERR, LOCK_LOST}), 32'd0);
    chk("arst_state", 32'(STATE), 32'd0);
    repeat (3) step();
    lbase = wr_log.size();
    PRESET_N = 1'b1;
    base = edge_n;
    wait_done(200);
    chk("arst_done_edge", 32'(edge_n - base), 32'(T_DONE));
    chk_writes("arst_rerun", lbase);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
